// File: rtl/switch_allocator.sv
// Output-side switch allocator for the 3-port (x, y, local) router.
// Round-robin arbitration per output, locked until tail or owner fail; drives registered mux selects.
//
// state  | meaning
// IDLE   | output free; control_p = 00, arbitrates among candidates each edge
// LOCKED | output owned by the input coded in control_p until its tail flit or a fail
module switch_allocator (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req_x,
   input  logic       req_y,
   input  logic       req_local,
   input  logic [1:0] dir_x,
   input  logic [1:0] dir_y,
   input  logic [1:0] dir_local,
   input  logic       tail_x,
   input  logic       tail_y,
   input  logic       tail_local,
   input  logic [2:0] out_ready,
   input  logic [2:0] fail,
   output logic [1:0] control_x,
   output logic [1:0] control_y,
   output logic [1:0] control_local,
   output logic       gnt_x,
   output logic       gnt_y,
   output logic       gnt_local
);

   typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

   state_t     state_q [3];
   state_t     state_d [3];
   logic [1:0] ctrl_q  [3];
   logic [1:0] ctrl_d  [3];
   logic [1:0] rr_q    [3];
   logic [1:0] rr_d    [3];
   logic [1:0] dir     [3];
   logic [2:0] req;
   logic [2:0] tail;
   logic [2:0] gnt;

   function automatic logic [1:0] nxt(input logic [1:0] i);
      return (i == 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

   assign req  = {req_local, req_y, req_x};
   assign tail = {tail_local, tail_y, tail_x};

   always_comb begin
      dir[0] = dir_x;
      dir[1] = dir_y;
      dir[2] = dir_local;
   end

   // Input and port indices share one numbering, so an index i is encoded as i+1.
   always_comb begin
      gnt = '0;
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 3; i++) begin
            if (state_q[p] == LOCKED && ctrl_q[p] == 2'(i + 1) && req[i] &&
                dir[i] == 2'(p + 1) && out_ready[p] && !fail[i])
               gnt[i] = 1'b1;
         end
      end
   end

   always_comb begin
      logic       found;
      logic [1:0] idx;
      logic [1:0] own;
      found = 1'b0;
      idx   = 2'd0;
      own   = 2'd0;
      for (int p = 0; p < 3; p++) begin
         state_d[p] = state_q[p];
         ctrl_d[p]  = ctrl_q[p];
         rr_d[p]    = rr_q[p];
      end
      for (int p = 0; p < 3; p++) begin
         found = 1'b0;
         idx   = rr_q[p];
         own   = ctrl_q[p] - 2'd1;
         case (state_q[p])
            IDLE: begin
               for (int k = 0; k < 3; k++) begin
                  if (!found && req[idx] && dir[idx] == 2'(p + 1) && !fail[idx]) begin
                     found      = 1'b1;
                     state_d[p] = LOCKED;
                     ctrl_d[p]  = idx + 2'd1;
                  end
                  idx = nxt(idx);
               end
            end
            LOCKED: begin
               // A failed owner aborts the packet; its grant is already suppressed.
               if (fail[own] || (gnt[own] && tail[own])) begin
                  state_d[p] = IDLE;
                  ctrl_d[p]  = 2'b00;
                  rr_d[p]    = nxt(own);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < 3; p++) begin
            state_q[p] <= IDLE;
            ctrl_q[p]  <= 2'b00;
            rr_q[p]    <= 2'd0;
         end
      end else begin
         for (int p = 0; p < 3; p++) begin
            state_q[p] <= state_d[p];
            ctrl_q[p]  <= ctrl_d[p];
            rr_q[p]    <= rr_d[p];
         end
      end
   end

   assign control_x     = ctrl_q[0];
   assign control_y     = ctrl_q[1];
   assign control_local = ctrl_q[2];
   assign gnt_x         = gnt[0];
   assign gnt_y         = gnt[1];
   assign gnt_local     = gnt[2];

endmodule

// File: tb/tb_switch_allocator.sv
// Scoreboard bench for switch_allocator: stimulus pushes per-cycle expectations,
// a monitor pops and compares them on the falling edge.
module tb_switch_allocator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_x, req_y, req_local;
   logic [1:0] dir_x, dir_y, dir_local;
   logic       tail_x, tail_y, tail_local;
   logic [2:0] out_ready;
   logic [2:0] fail;
   logic [1:0] control_x, control_y, control_local;
   logic       gnt_x, gnt_y, gnt_local;

   typedef struct {
      string      name;
      logic [1:0] cx;
      logic [1:0] cy;
      logic [1:0] cl;
      logic [2:0] g;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   switch_allocator dut (
      .clk(clk), .rst_n(rst_n),
      .req_x(req_x), .req_y(req_y), .req_local(req_local),
      .dir_x(dir_x), .dir_y(dir_y), .dir_local(dir_local),
      .tail_x(tail_x), .tail_y(tail_y), .tail_local(tail_local),
      .out_ready(out_ready), .fail(fail),
      .control_x(control_x), .control_y(control_y), .control_local(control_local),
      .gnt_x(gnt_x), .gnt_y(gnt_y), .gnt_local(gnt_local)
   );

   task automatic exp(input string n, input logic [1:0] cx, input logic [1:0] cy,
                      input logic [1:0] cl, input logic [2:0] g);
      exp_t e;
      e.name = n; e.cx = cx; e.cy = cy; e.cl = cl; e.g = g;
      q.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      req_x = 0; req_y = 0; req_local = 0;
      dir_x = 2'b00; dir_y = 2'b00; dir_local = 2'b00;
      tail_x = 0; tail_y = 0; tail_local = 0;
      out_ready = 3'b111; fail = 3'b000;
   endtask

   initial begin
      exp_t e;
      logic [8:0] act, want;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e    = q.pop_front();
            act  = {control_x, control_y, control_local, gnt_local, gnt_y, gnt_x};
            want = {e.cx, e.cy, e.cl, e.g};
            tests++;
            if (act !== want) begin
               fails++;
               $display("FAIL %s: got cx=%b cy=%b cl=%b gnt(l,y,x)=%b, want cx=%b cy=%b cl=%b gnt=%b",
                        e.name, control_x, control_y, control_local,
                        {gnt_local, gnt_y, gnt_x}, e.cx, e.cy, e.cl, e.g);
            end
         end
      end
   end

   initial begin
      int budget;
      rst_n = 1'b0;
      clr();
      repeat (2) @(posedge clk);
      #1;
      exp("reset", 2'b00, 2'b00, 2'b00, 3'b000); tick();
      rst_n = 1'b1;

      // single-flit packet y -> x
      req_y = 1; dir_y = 2'b01; tail_y = 1;
      exp("t1_idle", 2'b00, 2'b00, 2'b00, 3'b000); tick();
      exp("t1_lock", 2'b10, 2'b00, 2'b00, 3'b010); tick();
      req_y = 0;
      exp("t1_rel",  2'b00, 2'b00, 2'b00, 3'b000); tick();
      clr();

      // three-way contention for local, 2-flit packets
      req_x = 1; req_y = 1; req_local = 1;
      dir_x = 2'b11; dir_y = 2'b11; dir_local = 2'b11;
      exp("t2_idle", 2'b00, 2'b00, 2'b00, 3'b000); tick();
      exp("t2_x_f0", 2'b00, 2'b00, 2'b01, 3'b001); tick();
      tail_x = 1;
      exp("t2_x_f1", 2'b00, 2'b00, 2'b01, 3'b001); tick();
      req_x = 0; tail_x = 0;
      exp("t2_gap0", 2'b00, 2'b00, 2'b00, 3'b000); tick();
      exp("t2_y_f0", 2'b00, 2'b00, 2'b10, 3'b010); tick();
      tail_y = 1;
      exp("t2_y_f1", 2'b00, 2'b00, 2'b10, 3'b010); tick();
      req_y = 0; tail_y = 0;
      exp("t2_gap1", 2'b00, 2'b00, 2'b00, 3'b000); tick();
      exp("t2_l_f0", 2'b00, 2'b00, 2'b11, 3'b100); tick();
      tail_local = 1;
      exp("t2_l_f1", 2'b00, 2'b00, 2'b11, 3'b100); tick();
      req_local = 0; tail_local = 0;
      exp("t2_gap2", 2'b00, 2'b00, 2'b00, 3'b000); tick();
      clr();

      // backpressure on output y owned by x
      req_x = 1; dir_x = 2'b10;
      exp("t3_idle", 2'b00, 2'b00, 2'b00, 3'b000); tick();
      out_ready = 3'b101;
      for (int i = 0; i < 3; i++) begin
         exp("t3_stall", 2'b00, 2'b01, 2'b00, 3'b000); tick();
      end
      out_ready = 3'b111;
      exp("t3_resume", 2'b00, 2'b01, 2'b00, 3'b001); tick();
      tail_x = 1;
      exp("t3_tail", 2'b00, 2'b01, 2'b00, 3'b001); tick();
      req_x = 0; tail_x = 0;
      exp("t3_rel", 2'b00, 2'b00, 2'b00, 3'b000); tick();
      clr();

      // fail abort: rr_x points at local after the first test
      req_local = 1; dir_local = 2'b01;
      req_y = 1; dir_y = 2'b01; tail_y = 1;
      exp("t4_idle", 2'b00, 2'b00, 2'b00, 3'b000); tick();
      exp("t4_l_f0", 2'b11, 2'b00, 2'b00, 3'b100); tick();
      fail = 3'b100;
      exp("t4_fail", 2'b11, 2'b00, 2'b00, 3'b000); tick();
      exp("t4_abort", 2'b00, 2'b00, 2'b00, 3'b000); tick();
      exp("t4_y_win", 2'b10, 2'b00, 2'b00, 3'b010); tick();
      clr();
      exp("t4_rel", 2'b00, 2'b00, 2'b00, 3'b000); tick();

      // parallel allocation, then async reset mid-packet
      req_x = 1; dir_x = 2'b10;
      req_y = 1; dir_y = 2'b01;
      req_local = 1; dir_local = 2'b11;
      exp("t5_idle", 2'b00, 2'b00, 2'b00, 3'b000); tick();
      exp("t5_par", 2'b10, 2'b01, 2'b11, 3'b111); tick();
      rst_n = 1'b0;
      exp("t5_async_rst", 2'b00, 2'b00, 2'b00, 3'b000); tick();
      rst_n = 1'b1;
      clr();

      // direction 00 never allocates
      req_x = 1; req_y = 1; req_local = 1;
      exp("t6_inv0", 2'b00, 2'b00, 2'b00, 3'b000); tick();
      exp("t6_inv1", 2'b00, 2'b00, 2'b00, 3'b000); tick();
      exp("t6_inv2", 2'b00, 2'b00, 2'b00, 3'b000); tick();
      clr();

      // after reset rr_x restarts at x, so y beats local
      req_y = 1; dir_y = 2'b01; tail_y = 1;
      req_local = 1; dir_local = 2'b01;
      exp("t7_idle", 2'b00, 2'b00, 2'b00, 3'b000); tick();
      exp("t7_rr_reset", 2'b10, 2'b00, 2'b00, 3'b010); tick();
      clr();
      exp("t7_rel", 2'b00, 2'b00, 2'b00, 3'b000); tick();

      budget = 20;
      while (q.size() > 0 && budget > 0) begin
         tick();
         budget--;
      end
      if (q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
